apb_timer_multi: RTL and testbench
==================================

# apb_timer_multi

Multi-channel, width-parametrised APB timer: NUM_CH independent up/down counters, each with its own data, control, status and count register and a dedicated overflow and underflow flag output. It sits on the APB peripheral bus beside the existing single-channel 8-bit timer and is its drop-in successor. Each channel keeps the established TDR/TCR/TSR/TCNT programming model. New over the previous generation: channel replication, DATA_WIDTH generalisation, write-1-to-clear status, and optional auto-reload.

## Interface
- ADDR_WIDTH, 8, APB address width; must be ≥ clog2(NUM_CH)+2
- DATA_WIDTH, 8, counter/data width, 8..32
- NUM_CH, 4, channel count, 1..8
- PCLK  in  1  bus and counter clock, all logic on rising edge
- PRESET  in  1  asynchronous active-high reset
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  ADDR_WIDTH  {channel, reg[1:0]}
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- TMR_OVF  out  NUM_CH  per-channel TSR.OVF
- TMR_URF  out  NUM_CH  per-channel TSR.UDF

## Operation
- Address decode: ch = PADDR[ADDR_WIDTH-1:2]; reg = PADDR[1:0]. Offsets: 0 TDR (R/W), 1 TCR (R/W), 2 TSR (R/W1C), 3 TCNT (RO).
- Invalid access (ch ≥ NUM_CH, or write to TCNT):
  - PSLVERR=1 during the access phase.
  - No register changes.
  - PRDATA=0.
- TCR layout, bits [7:0]:
  - [7] Load, [6] ARE (auto-reload), [5] Up/Dw (1 = down), [4] En, [1:0] Cks.
  - Bits [3:2] and all bits above 7 are reserved; writes to them are ignored and they read 0.
- TSR layout:
  - [0] OVF, [1] UDF; writing 1 to a bit clears it.
  - All other bits read 0.
- Prescaler:
  - One shared 4-bit free-running counter, incremented every PCLK.
  - The channel tick fires for one cycle when prescaler[Cks:0] is all ones, giving a period of 2^(Cks+1) PCLK: 2, 4, 8 or 16.
- Per-channel counter update, in priority order:
  1. Load rising edge: Load=1 now and Load=0 in the previous cycle. TCNT <= TDR. A tick in the same cycle is ignored.
  2. En=1 and tick with Up/Dw=0: TCNT+1. At all-ones it wraps to 0, or to TDR if ARE=1, and sets OVF.
  3. En=1 and tick with Up/Dw=1: TCNT−1. At 0 it wraps to all-ones, or to TDR if ARE=1, and sets UDF.
- Flag priority: if a flag set and a W1C clear of that flag occur in the same cycle, the set wins.
- The Load bit is level-stored; software must write Load=0 before another load edge can occur.
- Writes to TDR alone never change TCNT.

## Timing
- PREADY = PSEL & PENABLE, combinational. Zero wait states; PREADY=0 outside the access phase.
- Writes commit on the PCLK edge that ends the access phase (PSEL & PENABLE & PWRITE).
- PRDATA:
  - Combinational mux, valid while PSEL & PENABLE & !PWRITE.
  - 0 at all other times.
- Latency:
  - TCNT and flags update on the edge following a tick-qualified cycle.
  - A TCR write setting Load takes effect one cycle after the write commits: the edge detector register updates, then TCNT loads.
- Reset (PRESET=1, asynchronous):
  - TDR, TCR, TSR, TCNT of all channels = 0; prescaler = 0; Load-edge history = 0.
  - Outputs: PRDATA=0, PREADY=0, PSLVERR=0, TMR_OVF=0, TMR_URF=0.
- Reset asserted mid-transfer aborts the transfer with no partial write.

## Configuration
- TIMER_ARE_EN defined: TCR[6] is implemented, and wrap reloads from TDR when ARE=1.
- TIMER_ARE_EN undefined:
  - TCR[6] is reserved and reads 0.
  - Counters always wrap to 0 on overflow and to all-ones on underflow.

## Test plan
- Reset, then read every valid address of all NUM_CH channels → all read 0; PSLVERR=0.
- Write 0xFF to TCR of channel 1, then read it back → 0xF3 with TIMER_ARE_EN, 0xB3 without. Read a non-existent channel (PADDR=NUM_CH<<2) → PSLVERR=1, PRDATA=0.
- Channel 0 overflow: TDR=0xFE, pulse Load, TCR=0x10 (up, Cks=00) → TCNT reaches 0xFF then 0x00 after 2 more ticks (4 PCLK). TMR_OVF[0]=1; other channels' flags stay 0.
- Channel 2 down with ARE (macro on): TDR=0x03, load, TCR=0x70 → TCNT sequence 3,2,1,0,3. TMR_URF[2]=1 on the wrap. Write TSR=0x02 → TMR_URF[2]=0.
- Prescaler: Cks=11, up from 0 → TCNT=1 after 16 PCLK, 2 after 32 PCLK. Same-cycle W1C of OVF and a new overflow → OVF stays 1.
- Assert PRESET during a TCNT-counting, flag-set state → all outputs 0 immediately, without waiting for a PCLK edge.

Source files
------------

// File: rtl/apb_timer_multi.sv
// rtl/apb_timer_multi.sv - NUM_CH-channel APB up/down timer with shared prescaler and W1C flags.
// Optional auto-reload on wrap is built when TIMER_ARE_EN is defined.
module apb_timer_multi #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [NUM_CH-1:0]     TMR_OVF,
    output logic [NUM_CH-1:0]     TMR_URF
);

`ifdef TIMER_ARE_EN
    localparam logic [7:0] TCR_MASK = 8'hF3;
    localparam bit         ARE_IMPL = 1'b1;
`else
    localparam logic [7:0] TCR_MASK = 8'hB3;
    localparam bit         ARE_IMPL = 1'b0;
`endif
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    logic [3:0]            presc_q, presc_d;
    logic [DATA_WIDTH-1:0] tdr_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] tdr_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] tcnt_q [NUM_CH];
    logic [DATA_WIDTH-1:0] tcnt_d [NUM_CH];
    logic [7:0]            tcr_q  [NUM_CH];
    logic [7:0]            tcr_d  [NUM_CH];
    logic [1:0]            tsr_q  [NUM_CH];
    logic [1:0]            tsr_d  [NUM_CH];
    logic [NUM_CH-1:0]     lprev_q, lprev_d;

    logic [ADDR_WIDTH-3:0] ch_sel;
    logic [1:0]            reg_sel;
    logic                  ch_ok, access, acc_err, wr_en;

    assign ch_sel  = PADDR[ADDR_WIDTH-1:2];
    assign reg_sel = PADDR[1:0];
    assign ch_ok   = (int'(ch_sel) < NUM_CH);
    // Bus outputs are forced quiet while reset is held, even mid-access.
    assign access  = PSEL & PENABLE & ~PRESET;
    assign acc_err = access & (~ch_ok | (PWRITE & (reg_sel == 2'd3)));
    assign wr_en   = access & PWRITE & ~acc_err;
    assign PREADY  = access;
    assign PSLVERR = acc_err;

    always_comb begin
        logic [3:0] tmask;
        logic       tick, set_ovf, set_udf;
        presc_d = presc_q + 4'd1;
        lprev_d = lprev_q;
        for (int i = 0; i < NUM_CH; i++) begin
            tdr_d[i]   = tdr_q[i];
            tcr_d[i]   = tcr_q[i];
            tsr_d[i]   = tsr_q[i];
            tcnt_d[i]  = tcnt_q[i];
            lprev_d[i] = tcr_q[i][7];
            set_ovf    = 1'b0;
            set_udf    = 1'b0;
            case (tcr_q[i][1:0])
                2'd0:    tmask = 4'b0001;
                2'd1:    tmask = 4'b0011;
                2'd2:    tmask = 4'b0111;
                default: tmask = 4'b1111;
            endcase
            tick = ((presc_q & tmask) == tmask);
            if (tcr_q[i][7] && !lprev_q[i]) begin
                tcnt_d[i] = tdr_q[i];
            end else if (tcr_q[i][4] && tick) begin
                if (!tcr_q[i][5]) begin
                    if (tcnt_q[i] == ALL_ONES) begin
                        tcnt_d[i] = (ARE_IMPL && tcr_q[i][6]) ? tdr_q[i] : '0;
                        set_ovf   = 1'b1;
                    end else begin
                        tcnt_d[i] = tcnt_q[i] + 1'b1;
                    end
                end else begin
                    if (tcnt_q[i] == '0) begin
                        tcnt_d[i] = (ARE_IMPL && tcr_q[i][6]) ? tdr_q[i] : ALL_ONES;
                        set_udf   = 1'b1;
                    end else begin
                        tcnt_d[i] = tcnt_q[i] - 1'b1;
                    end
                end
            end
            if (wr_en && (int'(ch_sel) == i)) begin
                case (reg_sel)
                    2'd0:    tdr_d[i] = PWDATA;
                    2'd1:    tcr_d[i] = PWDATA[7:0] & TCR_MASK;
                    2'd2:    tsr_d[i] = tsr_q[i] & ~PWDATA[1:0];
                    default: ;
                endcase
            end
            // A flag being set outranks a W1C clear in the same cycle.
            tsr_d[i] = tsr_d[i] | {set_udf, set_ovf};
        end
    end

    always_comb begin
        PRDATA  = '0;
        TMR_OVF = '0;
        TMR_URF = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            TMR_OVF[i] = tsr_q[i][0];
            TMR_URF[i] = tsr_q[i][1];
            if (access && !PWRITE && !acc_err && (int'(ch_sel) == i)) begin
                case (reg_sel)
                    2'd0:    PRDATA = tdr_q[i];
                    2'd1:    PRDATA = DATA_WIDTH'(tcr_q[i]);
                    2'd2:    PRDATA = DATA_WIDTH'(tsr_q[i]);
                    default: PRDATA = tcnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            presc_q <= '0;
            lprev_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tdr_q[i]  <= '0;
                tcr_q[i]  <= '0;
                tsr_q[i]  <= '0;
                tcnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            lprev_q <= lprev_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tdr_q[i]  <= tdr_d[i];
                tcr_q[i]  <= tcr_d[i];
                tsr_q[i]  <= tsr_d[i];
                tcnt_q[i] <= tcnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_timer_multi.sv
// tb/tb_apb_timer_multi.sv - self-checking bench for apb_timer_multi with a cycle-level reference model.
module tb_apb_timer_multi;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NCH = 4;
`ifdef TIMER_ARE_EN
    localparam bit         ARE  = 1'b1;
    localparam logic [7:0] TCRM = 8'hF3;
`else
    localparam bit         ARE  = 1'b0;
    localparam logic [7:0] TCRM = 8'hB3;
`endif
    localparam longint MAXV = (64'd1 << DW) - 1;

    logic          PCLK = 1'b0, PRESET = 1'b1;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [DW-1:0] PWDATA = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic [NCH-1:0] TMR_OVF, TMR_URF;

    apb_timer_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TMR_OVF(TMR_OVF), .TMR_URF(TMR_URF)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0, cyc = 0;

    logic [DW-1:0] m_tdr [NCH];
    logic [DW-1:0] m_tcnt[NCH];
    logic [7:0]    m_tcr [NCH];
    logic [1:0]    m_tsr [NCH];
    bit            m_lp  [NCH];
    int            m_cyc;

    logic [DW-1:0] wv[$];
    int            ws[$];

    typedef struct {
        logic [AW-1:0] addr;
        bit            wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int a, input bit w, input int d, input int e, input bit er);
        vec_t v;
        v.addr = AW'(a); v.wr = w; v.wdata = DW'(d); v.exp_rd = DW'(e); v.exp_err = er;
        return v;
    endfunction

    function automatic bit merr(input logic [AW-1:0] a, input bit w);
        return (int'(a >> 2) >= NCH) || (w && (a[1:0] == 2'd3));
    endfunction

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        int ch = int'(a >> 2);
        if (ch >= NCH) return '0;
        case (a[1:0])
            2'd0:    return m_tdr[ch];
            2'd1:    return DW'(m_tcr[ch]);
            2'd2:    return DW'(m_tsr[ch]);
            default: return m_tcnt[ch];
        endcase
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            m_tdr[c] = '0; m_tcnt[c] = '0; m_tcr[c] = '0; m_tsr[c] = '0; m_lp[c] = 1'b0;
        end
    endtask

    // Applies one PCLK edge worth of the programming-model rules to the model state.
    task automatic model_step();
        int per, ch;
        bit tk, wr;
        logic [1:0] setf, nsr;
        logic [DW-1:0] nt, ntdr;
        logic [7:0] ntcr;
        longint v;
        ch = int'(PADDR >> 2);
        wr = PSEL && PENABLE && PWRITE && !merr(PADDR, 1'b1);
        for (int c = 0; c < NCH; c++) begin
            per  = 2 << m_tcr[c][1:0];
            tk   = ((m_cyc % per) == per - 1);
            setf = 2'b00;
            nt   = m_tcnt[c];
            v    = longint'(m_tcnt[c]);
            if (m_tcr[c][7] && !m_lp[c]) nt = m_tdr[c];
            else if (m_tcr[c][4] && tk) begin
                if (!m_tcr[c][5]) begin
                    if (v + 1 > MAXV) begin
                        nt = (ARE && m_tcr[c][6]) ? m_tdr[c] : DW'(0);
                        setf[0] = 1'b1;
                    end else nt = DW'(v + 1);
                end else begin
                    if (v - 1 < 0) begin
                        nt = (ARE && m_tcr[c][6]) ? m_tdr[c] : DW'(MAXV);
                        setf[1] = 1'b1;
                    end else nt = DW'(v - 1);
                end
            end
            nsr = m_tsr[c]; ntdr = m_tdr[c]; ntcr = m_tcr[c];
            if (wr && ch == c) begin
                case (PADDR[1:0])
                    2'd0:    ntdr = PWDATA;
                    2'd1:    ntcr = PWDATA[7:0] & TCRM;
                    2'd2:    nsr  = nsr & ~PWDATA[1:0];
                    default: ;
                endcase
            end
            m_lp[c]   = m_tcr[c][7];
            m_tcnt[c] = nt;
            m_tsr[c]  = nsr | setf;
            m_tdr[c]  = ntdr;
            m_tcr[c]  = ntcr;
        end
        m_cyc = (m_cyc + 1) % 16;
    endtask

    task automatic step();
        logic [NCH-1:0] eo, eu;
        model_step();
        @(posedge PCLK);
        @(negedge PCLK);
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            eo[c] = m_tsr[c][0];
            eu[c] = m_tsr[c][1];
        end
        check("tmr_ovf", 32'(TMR_OVF), 32'(eo));
        check("tmr_urf", 32'(TMR_URF), 32'(eu));
    endtask

    task automatic apb_xfer(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d, input bit chk,
                            output logic [DW-1:0] rd, output bit er);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        #1;
        check("pready_setup", 32'(PREADY), 32'd0);
        step();
        PENABLE = 1'b1;
        #1;
        check("pready_access", 32'(PREADY), 32'd1);
        rd = PRDATA; er = PSLVERR;
        if (chk) begin
            check("prdata_model", 32'(rd), w ? 32'd0 : 32'(mread(a)));
            check("pslverr_model", 32'(er), 32'(merr(a, w)));
        end
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_wr(input int a, input int d);
        logic [DW-1:0] rd; bit er;
        apb_xfer(AW'(a), 1'b1, DW'(d), 1'b1, rd, er);
    endtask

    task automatic apb_rd_const(input string name, input int a, input int exp);
        logic [DW-1:0] rd; bit er;
        apb_xfer(AW'(a), 1'b0, '0, 1'b1, rd, er);
        check(name, 32'(rd), 32'(exp));
    endtask

    task automatic watch(input int a, input int n);
        logic [DW-1:0] v;
        wv.delete(); ws.delete();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AW'(a);
        step();
        PENABLE = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            v = PRDATA;
            check("watch_prdata", 32'(v), 32'(mread(AW'(a))));
            if (wv.size() == 0 || wv[$] != v) begin
                wv.push_back(v);
                ws.push_back(cyc);
            end
            step();
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic int find_val(input logic [DW-1:0] v);
        for (int k = 0; k < wv.size(); k++) if (wv[k] == v) return k;
        return -1;
    endfunction

    initial begin
        logic [DW-1:0] rd, exps[5];
        bit er;
        int k, off;
        logic [AW-1:0] ra;

        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_prdata", 32'(PRDATA), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_ovf", 32'(TMR_OVF), 32'd0);
        check("rst_urf", 32'(TMR_URF), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        for (int i = 0; i < NCH * 4; i++) vt.push_back(mk(i, 1'b0, 0, 0, 1'b0));
        vt.push_back(mk(5, 1'b1, 'hFF, 0, 1'b0));
        vt.push_back(mk(5, 1'b0, 0, int'(TCRM), 1'b0));
        vt.push_back(mk(NCH * 4, 1'b0, 0, 0, 1'b1));
        vt.push_back(mk(3, 1'b1, 'h12, 0, 1'b1));
        vt.push_back(mk(3, 1'b0, 0, 0, 1'b0));
        vt.push_back(mk(5, 1'b1, 0, 0, 1'b0));
        vt.push_back(mk(6, 1'b1, 3, 0, 1'b0));
        vt.push_back(mk(6, 1'b0, 0, 0, 1'b0));
        for (int i = 0; i < vt.size(); i++) begin
            apb_xfer(vt[i].addr, vt[i].wr, vt[i].wdata, 1'b1, rd, er);
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].exp_rd));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
        end

        // Channel 0 up-count overflow from 0xFE.
        apb_wr(0, 'hFE); apb_wr(1, 'h80); apb_wr(1, 'h00);
        apb_rd_const("ch0_loaded", 3, 'hFE);
        apb_wr(1, 'h10);
        watch(3, 8);
        k = find_val(DW'(MAXV));
        check("ch0_saw_ff", 32'(k >= 0), 32'd1);
        if (k >= 0 && k + 1 < wv.size()) begin
            check("ch0_wrap_val", 32'(wv[k+1]), 32'd0);
            check("ch0_wrap_gap", 32'(ws[k+1] - ws[k]), 32'd2);
        end else check("ch0_wrap_seen", 32'd0, 32'd1);
        apb_wr(1, 'h00);
        check("ch0_ovf_only", 32'(TMR_OVF), 32'b0001);
        check("ch0_no_urf", 32'(TMR_URF), 32'd0);

        // Channel 2 down-count through zero, reload or all-ones wrap.
        apb_wr(8, 3); apb_wr(9, 'h80); apb_wr(9, 'h00);
        apb_rd_const("ch2_loaded", 11, 3);
        apb_wr(9, 'h70);
        watch(11, 12);
        exps[0] = 3; exps[1] = 2; exps[2] = 1; exps[3] = 0; exps[4] = ARE ? DW'(3) : DW'(MAXV);
        off = (wv[0] == 3) ? 0 : 1;
        for (int j = 0; j + off < 5; j++) begin
            if (j < wv.size()) check($sformatf("ch2_seq%0d", j + off), 32'(wv[j]), 32'(exps[j+off]));
            else check("ch2_seq_short", 32'(wv.size()), 32'(5 - off));
        end
        apb_wr(9, 'h00);
        check("ch2_urf", 32'(TMR_URF), 32'b0100);
        apb_wr(10, 2);
        check("ch2_urf_clr", 32'(TMR_URF[2]), 32'd0);

        // Channel 3 with Cks=3 counts once per 16 PCLK.
        apb_wr(13, 'h80); apb_wr(13, 'h13);
        watch(15, 56);
        k = find_val(DW'(1));
        if (k >= 0 && k + 2 < wv.size()) begin
            check("presc_v2", 32'(wv[k+1]), 32'd2);
            check("presc_gap12", 32'(ws[k+1] - ws[k]), 32'd16);
            check("presc_gap23", 32'(ws[k+2] - ws[k+1]), 32'd16);
        end else check("presc_seen", 32'd0, 32'd1);
        apb_wr(13, 'h00);

        // W1C of OVF lands on the same edge as a new overflow.
        apb_wr(0, 'hFF); apb_wr(1, 'h80); apb_wr(1, 'h00); apb_wr(2, 1);
        check("ovf_precleared", 32'(TMR_OVF[0]), 32'd0);
        while (m_cyc % 2 != 0) step();
        apb_wr(1, 'h10);
        apb_wr(2, 1);
        check("ovf_set_wins", 32'(TMR_OVF[0]), 32'd1);
        apb_wr(1, 'h00);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ra = AW'($urandom);
            else ra = AW'(($urandom_range(0, NCH) << 2) | $urandom_range(0, 3));
            apb_xfer(ra, bit'($urandom_range(0, 1)), DW'($urandom), 1'b1, rd, er);
            if ($urandom_range(0, 3) == 0) step();
        end

        // Asynchronous reset while counting with a flag set and a read in progress.
        apb_wr(1, 'h00); apb_wr(0, 'hFF); apb_wr(1, 'h80); apb_wr(1, 'h10);
        repeat (4) step();
        check("pre_rst_ovf", 32'(TMR_OVF[0]), 32'd1);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = AW'(2);
        #2 PRESET = 1'b1;
        #1;
        check("arst_prdata", 32'(PRDATA), 32'd0);
        check("arst_pready", 32'(PREADY), 32'd0);
        check("arst_pslverr", 32'(PSLVERR), 32'd0);
        check("arst_ovf", 32'(TMR_OVF), 32'd0);
        check("arst_urf", 32'(TMR_URF), 32'd0);
        model_reset();
        @(negedge PCLK);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        apb_rd_const("arst_tcnt0", 3, 0);
        apb_rd_const("arst_tcr0", 1, 0);

        // Reset during a write access phase must leave TDR untouched.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(4); PWDATA = DW'('h5A);
        step();
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        model_reset();
        @(negedge PCLK);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_rd_const("abort_tdr1", 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
